// File: rtl/decode_hazard_stage_if.sv
// Decode-stage bus: fetch inputs, writeback port, EX hazard info and the
// decoded operands/hazard outputs. The optional hazard-statistics counters
// appear only when HAZARD_STATS_EN is defined.
// master = driver of the stage inputs (fetch/EX/WB side), slave = decode stage.
interface decode_hazard_stage_if #(
  parameter int N  = 64,
  parameter int AW = 5
);
  // Inputs to the decode stage
  logic [31:0]   instr_F;
  logic [N-1:0]  pc_F;
  logic          flush_D;
  logic          reg2loc_D;
  logic          regWrite_W;
  logic [AW-1:0] wa3_W;
  logic [N-1:0]  writeData3_W;
  logic          memRead_E;
  logic [AW-1:0] wa_E;

  // Outputs of the decode stage
  logic [31:0]   instr_D;
  logic [N-1:0]  pc_D;
  logic          valid_D;
  logic [AW-1:0] ra1_D;
  logic [AW-1:0] ra2_D;
  logic [N-1:0]  readData1_D;
  logic [N-1:0]  readData2_D;
  logic [N-1:0]  signImm_D;
  logic          stall_F;
  logic          bubble_E;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stallCount_D;
  logic [31:0]   flushCount_D;
`endif

  modport master (
    output instr_F, pc_F, flush_D, reg2loc_D, regWrite_W, wa3_W, writeData3_W,
           memRead_E, wa_E,
    input  instr_D, pc_D, valid_D, ra1_D, ra2_D, readData1_D, readData2_D,
           signImm_D, stall_F, bubble_E
`ifdef HAZARD_STATS_EN
           , stallCount_D, flushCount_D
`endif
  );

  modport slave (
    input  instr_F, pc_F, flush_D, reg2loc_D, regWrite_W, wa3_W, writeData3_W,
           memRead_E, wa_E,
    output instr_D, pc_D, valid_D, ra1_D, ra2_D, readData1_D, readData2_D,
           signImm_D, stall_F, bubble_E
`ifdef HAZARD_STATS_EN
           , stallCount_D, flushCount_D
`endif
  );
endinterface

// File: rtl/decode_hazard_stage.sv
// LEGv8 decode stage: IF/ID register with stall/flush, register file with
// write-through bypass and XZR, load-use hazard detection and a D/CB/B
// sign-extender. Optional feature macro: HAZARD_STATS_EN (stall/flush
// saturating counters). Reset is synchronous and active-low.
// N must be >= 26 so the B-format immediate fits (wider immediates truncate).
module decode_hazard_stage #(
  parameter int N    = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  decode_hazard_stage_if.slave  bus
);

  localparam logic [AW-1:0] XZR = AW'(NREG - 1);

  // IF/ID state
  logic [31:0]   instr_q, instr_d;
  logic [N-1:0]  pc_q, pc_d;
  logic          valid_q, valid_d;

  // Register file
  logic [N-1:0]  rf_q [NREG];

  logic [AW-1:0] ra1, ra2;
  logic          stall;

  // IF/ID next state: flush beats stall, stall beats load
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (bus.flush_D) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = bus.instr_F;
      pc_d    = bus.pc_F;
      valid_d = 1'b1;
    end
  end

  // IF/ID register with synchronous active-low reset
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Register-file write port; XZR is never written
  // NOTE: this array is reset on purpose (architectural requirement), which
  // rules out RAM-macro inference; it maps to flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (bus.regWrite_W && (bus.wa3_W != XZR)) begin
      rf_q[bus.wa3_W] <= bus.writeData3_W;
    end
  end

  // Read addresses and combinational read ports with write-through bypass
  always_comb begin
    ra1 = instr_q[9:5];
    ra2 = bus.reg2loc_D ? instr_q[4:0] : instr_q[20:16];

    if (ra1 == XZR)                                   bus.readData1_D = '0;
    else if (bus.regWrite_W && (bus.wa3_W == ra1))    bus.readData1_D = bus.writeData3_W;
    else                                              bus.readData1_D = rf_q[ra1];

    if (ra2 == XZR)                                   bus.readData2_D = '0;
    else if (bus.regWrite_W && (bus.wa3_W == ra2))    bus.readData2_D = bus.writeData3_W;
    else                                              bus.readData2_D = rf_q[ra2];
  end

  // Load-use hazard: a load in EX targeting a register this instruction reads
  always_comb begin
    stall = valid_q && bus.memRead_E && (bus.wa_E != XZR) &&
            ((bus.wa_E == ra1) || (bus.wa_E == ra2));
  end

  // Immediate extraction and sign extension by instruction format
  always_comb begin
    bus.signImm_D = '0;
    if ((instr_q[31:21] == 11'b11111000010) || (instr_q[31:21] == 11'b11111000000))
      bus.signImm_D = N'($signed(instr_q[20:12]));
    else if (instr_q[31:24] == 8'b10110100)
      bus.signImm_D = N'($signed(instr_q[23:5]));
    else if (instr_q[31:26] == 6'b000101)
      bus.signImm_D = N'($signed(instr_q[25:0]));
  end

  assign bus.instr_D  = instr_q;
  assign bus.pc_D     = pc_q;
  assign bus.valid_D  = valid_q;
  assign bus.ra1_D    = ra1;
  assign bus.ra2_D    = ra2;
  assign bus.stall_F  = stall;
  assign bus.bubble_E = stall || !valid_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters; a simultaneous flush and stall counts only as a flush
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush_D) begin
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stallCount_D = stall_cnt_q;
  assign bus.flushCount_D = flush_cnt_q;
`endif

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Scoreboard bench for decode_hazard_stage: the stimulus process drives one
// input vector per cycle, evaluates an architectural model and queues the
// expected outputs; a monitor on the falling edge pops and compares.
module tb_decode_hazard_stage;
  localparam int N    = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_hazard_stage_if #(.N(N), .AW(AW)) bus ();
  decode_hazard_stage #(.N(N), .NREG(NREG), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        flush;
    logic        reg2loc;
    logic        we;
    logic [4:0]  wa3;
    logic [63:0] wd;
    logic        mem_rd;
    logic [4:0]  wa_e;
  } stim_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        valid;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic        stall;
    logic        bubble;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Architectural model state
  logic [63:0] m_regs [NREG];
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  bit          m_valid;
  bit          m_known = 0;
  longint      m_scnt, m_fcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [4:0] ra, input stim_t s);
    if (ra == 5'd31) return 64'd0;
    if (s.we && s.wa3 == ra) return s.wd;
    return m_regs[ra];
  endfunction

  // Immediate as a signed integer value computed arithmetically
  function automatic logic [63:0] m_imm(input logic [31:0] i);
    longint v;
    if (i[31:21] == 11'h7C2 || i[31:21] == 11'h7C0) begin
      v = longint'(i[20:12]);
      if (v >= 256) v -= 512;
    end else if (i[31:24] == 8'hB4) begin
      v = longint'(i[23:5]);
      if (v >= (1 << 18)) v -= (1 << 19);
    end else if (i[31:26] == 6'b000101) begin
      v = longint'(i[25:0]);
      if (v >= (1 << 25)) v -= (1 << 26);
    end else begin
      v = 0;
    end
    return 64'(v);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.instr = '0; s.pc = '0; s.flush = 1'b0; s.reg2loc = 1'b0;
    s.we = 1'b0; s.wa3 = '0; s.wd = '0; s.mem_rd = 1'b0; s.wa_e = '0;
    return s;
  endfunction

  // Drive one cycle, queue its expectation, advance the model across the edge
  task automatic step(input stim_t s);
    exp_t e;
    bit   stall;
    reset             = s.rst;
    bus.instr_F       = s.instr;
    bus.pc_F          = s.pc;
    bus.flush_D       = s.flush;
    bus.reg2loc_D     = s.reg2loc;
    bus.regWrite_W    = s.we;
    bus.wa3_W         = s.wa3;
    bus.writeData3_W  = s.wd;
    bus.memRead_E     = s.mem_rd;
    bus.wa_E          = s.wa_e;
    stall = 0;
    if (m_known) begin
      e.instr  = m_instr;
      e.pc     = m_pc;
      e.valid  = m_valid;
      e.ra1    = m_instr[9:5];
      e.ra2    = s.reg2loc ? m_instr[4:0] : m_instr[20:16];
      e.rd1    = m_read(e.ra1, s);
      e.rd2    = m_read(e.ra2, s);
      e.imm    = m_imm(m_instr);
      stall    = m_valid && s.mem_rd && s.wa_e != 5'd31 &&
                 (s.wa_e == e.ra1 || s.wa_e == e.ra2);
      e.stall  = stall;
      e.bubble = stall || !m_valid;
      e.scnt   = 32'(m_scnt);
      e.fcnt   = 32'(m_fcnt);
      sb_q.push_back(e);
    end
    if (!s.rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_instr = '0; m_pc = '0; m_valid = 0; m_scnt = 0; m_fcnt = 0;
      m_known = 1;
    end else if (m_known) begin
      if (s.we && s.wa3 != 5'd31) m_regs[s.wa3] = s.wd;
      if (s.flush) begin
        m_instr = '0; m_valid = 0;
        if (m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      end else if (stall) begin
        if (m_scnt < 64'hFFFF_FFFF) m_scnt++;
      end else begin
        m_instr = s.instr; m_pc = s.pc; m_valid = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented output vector against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("instr_D",     64'(bus.instr_D),     64'(e.instr));
        check("pc_D",        bus.pc_D,             e.pc);
        check("valid_D",     64'(bus.valid_D),     64'(e.valid));
        check("ra1_D",       64'(bus.ra1_D),       64'(e.ra1));
        check("ra2_D",       64'(bus.ra2_D),       64'(e.ra2));
        check("readData1_D", bus.readData1_D,      e.rd1);
        check("readData2_D", bus.readData2_D,      e.rd2);
        check("signImm_D",   bus.signImm_D,        e.imm);
        check("stall_F",     64'(bus.stall_F),     64'(e.stall));
        check("bubble_E",    64'(bus.bubble_E),    64'(e.bubble));
`ifdef HAZARD_STATS_EN
        check("stallCount_D", 64'(bus.stallCount_D), 64'(e.scnt));
        check("flushCount_D", 64'(bus.flushCount_D), 64'(e.fcnt));
`endif
      end
    end
  end

  function automatic logic [4:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    stim_t s;
    int    sel;

    // Reset for two cycles, then sweep every read address
    s = idle(); s.rst = 1'b0;
    step(s); step(s);
    for (int k = 0; k < 32; k++) begin
      s = idle();
      s.instr   = (32'(k) << 5) | 32'(k);
      s.reg2loc = k[0];
      step(s);
    end

    // X3 write with same-cycle bypass, then storage read
    s = idle(); s.instr = 32'(3) << 5; step(s);
    s.we = 1'b1; s.wa3 = 5'd3; s.wd = 64'h1234; step(s);
    s.we = 1'b0; step(s); step(s);

    // XZR write is ignored
    s = idle(); s.we = 1'b1; s.wa3 = 5'd31; s.wd = 64'hFF; step(s);
    s.we = 1'b0; s.instr = 32'(31) << 5; step(s); step(s);

    // Load-use stall: hold for three cycles, then release
    s = idle(); s.instr = 32'(5) << 5; s.pc = 64'h100; step(s);
    s.instr = 32'hAAAA; s.pc = 64'h200; s.mem_rd = 1'b1; s.wa_e = 5'd5;
    step(s); step(s); step(s);
    s.mem_rd = 1'b0; step(s); step(s);

    // Flush while stalled
    s = idle(); s.instr = 32'(5) << 5; step(s);
    s.mem_rd = 1'b1; s.wa_e = 5'd5; step(s);
    s.flush = 1'b1; step(s);
    s.flush = 1'b0; step(s); step(s);

    // Sign extension: LDUR negative offset, B all-ones
    s = idle(); s.instr = 32'hF85F83E1; step(s);
    s.instr = 32'h17FFFFFF; step(s); step(s);

    // Fresh reset, then 3 stall cycles followed by a flush
    s = idle(); s.rst = 1'b0; step(s);
    s = idle(); s.instr = 32'(5) << 5; step(s);
    s.mem_rd = 1'b1; s.wa_e = 5'd5; step(s); step(s); step(s);
    s.flush = 1'b1; step(s);
    s = idle(); step(s); step(s);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      sel = $urandom_range(0, 4);
      case (sel)
        0: s.instr = {11'h7C2, 9'($urandom), 2'b00, rreg(), rreg()};
        1: s.instr = {11'h7C0, 9'($urandom), 2'b00, rreg(), rreg()};
        2: s.instr = {8'hB4, 19'($urandom), rreg()};
        3: s.instr = {6'b000101, 26'($urandom)};
        default: s.instr = {11'($urandom), rreg(), 6'($urandom), rreg(), rreg()};
      endcase
      s.pc      = {$urandom, $urandom};
      s.flush   = ($urandom_range(0, 9) == 0);
      s.reg2loc = 1'($urandom);
      s.we      = 1'($urandom);
      s.wa3     = rreg();
      s.wd      = {$urandom, $urandom};
      s.mem_rd  = 1'($urandom);
      case ($urandom_range(0, 3))
        0: s.wa_e = m_instr[9:5];
        1: s.wa_e = m_instr[4:0];
        2: s.wa_e = m_instr[20:16];
        default: s.wa_e = rreg();
      endcase
      step(s);
    end

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
